// File: rtl/glorb_pkg.sv
// Shared encodings, instruction field positions and sequencer state type for glorbcore.
// Used by glorb_sequencer (optional single-step feature: GLORB_SEQ_STEP_EN) and glorb_regfile.
package glorb_pkg;

    localparam logic       OP_R  = 1'b0;
    localparam logic       OP_B  = 1'b1;

    localparam logic [1:0] R_AND = 2'b00;
    localparam logic [1:0] R_OR  = 2'b01;
    localparam logic [1:0] R_ADD = 2'b10;
    localparam logic [1:0] R_XOR = 2'b11;

    localparam logic       B_BEQ = 1'b0;
    localparam logic       B_BLT = 1'b1;

    localparam int TYPE_BIT   = 0;
    localparam int BFUNCT_BIT = 1;
    localparam int FUNCT_LO   = 2;
    localparam int FUNCT_HI   = 3;
    localparam int RD_LO      = 4;
    localparam int RD_HI      = 5;
    localparam int RS1_LO     = 6;
    localparam int RS1_HI     = 7;
    localparam int IMM_LO     = 2;
    localparam int IMM_HI     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_e;

    function automatic logic is_btype(input logic [7:0] instr);
        return instr[TYPE_BIT] == OP_B;
    endfunction

    function automatic logic [1:0] field_rs1(input logic [7:0] instr);
        return instr[RS1_HI:RS1_LO];
    endfunction

    function automatic logic [1:0] field_rd(input logic [7:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

endpackage

// File: rtl/glorb_regfile.sv
// Four-entry architectural register file: three combinational read ports and one
// write port shared by writeback and debug, with writeback taking priority.
module glorb_regfile
    import glorb_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    rs1_sel,
    input  logic [1:0]    rd_sel,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] dbg_data,
    input  logic          wb_we,
    input  logic [1:0]    wb_sel,
    input  logic [DW-1:0] wb_data,
    input  logic          dbg_we,
    input  logic [DW-1:0] dbg_wdata
);

    logic [DW-1:0] rf_r [4];

    // Register storage; writeback wins if both ports fire in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= {DW{1'b0}};
            end
        end else if (wb_we) begin
            rf_r[wb_sel] <= wb_data;
        end else if (dbg_we) begin
            rf_r[dbg_sel] <= dbg_wdata;
        end
    end

    assign rs1_data = rf_r[rs1_sel];
    assign rd_data  = rf_r[rd_sel];
    assign dbg_data = rf_r[dbg_sel];

endmodule

// File: rtl/glorb_sequencer.sv
// Multi-cycle fetch/execute/writeback control for the glorbcore 8-bit datapath.
// Define GLORB_SEQ_STEP_EN to add a 'step' input that runs one instruction from IDLE.
module glorb_sequencer
    import glorb_pkg::*;
#(
    parameter int DW = 8,
    parameter int IW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
`ifdef GLORB_SEQ_STEP_EN
    input  logic          step,
`endif
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] alu_instr,
    output logic [DW-1:0] alu_rs1,
    output logic [DW-1:0] alu_rd,
    input  logic [DW-1:0] alu_out,
    output logic          retire,
    output logic          busy,
    input  logic          dbg_we,
    input  logic [1:0]    dbg_sel,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata
);

    state_e        state_r;
    state_e        state_s;
    logic [AW-1:0] pc_r;
    logic [IW-1:0] instr_r;
    logic [DW-1:0] res_r;
    logic          start_s;
    logic          cont_s;
    logic          is_b_s;
    logic [1:0]    rs1_sel_s;
    logic [1:0]    rd_sel_s;
    logic [DW-1:0] rs1_data_s;
    logic [DW-1:0] rd_data_s;

`ifdef GLORB_SEQ_STEP_EN
    logic step_mode_r;

    // Remember whether the current instruction was launched by a step rather than run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_mode_r <= 1'b0;
        end else if (state_r == IDLE) begin
            step_mode_r <= ~run & step;
        end
    end

    assign start_s = run | step;
    assign cont_s  = run & ~step_mode_r;
`else
    assign start_s = run;
    assign cont_s  = run;
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    state_s = EXEC;
                end else begin
                    state_s = FETCH;
                end
            end
            EXEC: state_s = WB;
            WB: begin
                if (cont_s) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, PC, latched instruction and ALU result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            pc_r    <= {AW{1'b0}};
            instr_r <= {IW{1'b0}};
            res_r   <= {DW{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == FETCH && imem_ack) begin
                instr_r <= imem_rdata;
            end
            if (state_r == EXEC) begin
                res_r <= alu_out;
            end
            if (state_r == WB) begin
                pc_r <= is_b_s ? pc_r + AW'(res_r) : pc_r + AW'(1'b1);
            end
        end
    end

    // Branches always compare r0 against r1; R-type reads its encoded fields.
    assign is_b_s    = is_btype(instr_r[7:0]);
    assign rs1_sel_s = is_b_s ? 2'd0 : field_rs1(instr_r[7:0]);
    assign rd_sel_s  = is_b_s ? 2'd1 : field_rd(instr_r[7:0]);

    glorb_regfile #(.DW(DW)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_sel   (rs1_sel_s),
        .rd_sel    (rd_sel_s),
        .dbg_sel   (dbg_sel),
        .rs1_data  (rs1_data_s),
        .rd_data   (rd_data_s),
        .dbg_data  (dbg_rdata),
        .wb_we     (state_r == WB && !is_b_s),
        .wb_sel    (field_rd(instr_r[7:0])),
        .wb_data   (res_r),
        .dbg_we    (dbg_we && state_r == IDLE),
        .dbg_wdata (dbg_wdata)
    );

    assign imem_req  = (state_r == FETCH);
    assign imem_addr = pc_r;
    assign retire    = (state_r == WB);
    assign busy      = (state_r != IDLE);
    assign alu_instr = busy ? instr_r : {IW{1'b0}};
    assign alu_rs1   = busy ? rs1_data_s : {DW{1'b0}};
    assign alu_rd    = busy ? rd_data_s : {DW{1'b0}};

endmodule

// File: tb/tb_glorb_sequencer.sv
// Randomized and directed bench for glorb_sequencer against an architectural-level model
// (PC, register array, idle/fetching status) with a stand-in combinational ALU.
module tb_glorb_sequencer;
    import glorb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] alu_instr;
    logic [7:0] alu_rs1;
    logic [7:0] alu_rd;
    logic [7:0] alu_out;
    logic       retire;
    logic       busy;
    logic       dbg_we;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_wdata;
    logic [7:0] dbg_rdata;
    logic       taken_s;
`ifdef GLORB_SEQ_STEP_EN
    logic       step = 1'b0;
`endif

    always #5 clk = ~clk;

    glorb_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef GLORB_SEQ_STEP_EN
        .step       (step),
`endif
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_instr  (alu_instr),
        .alu_rs1    (alu_rs1),
        .alu_rd     (alu_rd),
        .alu_out    (alu_out),
        .retire     (retire),
        .busy       (busy),
        .dbg_we     (dbg_we),
        .dbg_sel    (dbg_sel),
        .dbg_wdata  (dbg_wdata),
        .dbg_rdata  (dbg_rdata)
    );

    // Stand-in for the parent core's combinational ALU.
    always_comb begin
        alu_out = 8'h00;
        taken_s = 1'b0;
        if (alu_instr[0] == OP_R) begin
            case (alu_instr[3:2])
                R_ADD:   alu_out = alu_rs1 + alu_rd;
                R_AND:   alu_out = alu_rs1 & alu_rd;
                R_OR:    alu_out = alu_rs1 | alu_rd;
                default: alu_out = alu_rs1 ^ alu_rd;
            endcase
        end else begin
            taken_s = (alu_instr[1] == B_BLT) ? (alu_rs1 < alu_rd) : (alu_rs1 == alu_rd);
            alu_out = taken_s ? {2'b00, alu_instr[7:2]} : 8'h01;
        end
    end

    logic [7:0] mem [256];
    logic [7:0] m_rf [4];
    logic [7:0] m_pc;
    logic [7:0] m_instr;
    bit         m_idle;
    bit         m_fetch;
    bit         fetch_prev;
    logic [7:0] addr_prev;
    logic [7:0] last_fetch_addr;
    logic [7:0] fetch_log [$];
    int         ack_cnt;
    int         wcnt;
    int         force_wait;
    int         retire_cnt;
    bit         rand_wait;
    bit         rand_ack;
    int         checks;
    int         failures;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Architectural effect of one instruction, straight from the instruction-set rules.
    task automatic apply_instr(input logic [7:0] ins);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        bit         tk;
        if (ins[0] == 1'b0) begin
            a = m_rf[ins[7:6]];
            b = m_rf[ins[5:4]];
            case (ins[3:2])
                2'b10:   r = a + b;
                2'b00:   r = a & b;
                2'b01:   r = a | b;
                default: r = a ^ b;
            endcase
            m_rf[ins[5:4]] = r;
            m_pc = m_pc + 8'd1;
        end else begin
            tk = ins[1] ? (m_rf[0] < m_rf[1]) : (m_rf[0] == m_rf[1]);
            m_pc = m_pc + (tk ? {2'b00, ins[7:2]} : 8'd1);
        end
    endtask

    task automatic next_wait(output int w);
        if (force_wait >= 0) begin
            w = force_wait;
            force_wait = -1;
        end else if (rand_wait) begin
            w = int'($urandom_range(0, 3));
        end else begin
            w = 0;
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_pc = 8'h00; m_instr = 8'h00;
        m_idle = 1'b1; m_fetch = 1'b0; fetch_prev = 1'b0;
        ack_cnt = -1; wcnt = 0; force_wait = -1;
    endtask

    // One cycle: check outputs at the falling edge, then respond and advance the model.
    task automatic tick();
        bit exp_ret;
        bit acked;
        if (ack_cnt >= 0) ack_cnt++;
        exp_ret = (ack_cnt == 2);
        check_val("busy", 32'(busy), 32'(!m_idle));
        check_val("imem_req", 32'(imem_req), 32'(m_fetch));
        check_val("retire", 32'(retire), 32'(exp_ret));
        if (retire) retire_cnt++;
        if (m_fetch) begin
            if (!fetch_prev) begin
                check_val("fetch_addr", 32'(imem_addr), 32'(m_pc));
                last_fetch_addr = imem_addr;
                fetch_log.push_back(imem_addr);
            end else begin
                check_val("addr_stable", 32'(imem_addr), 32'(addr_prev));
            end
        end
        check_val("dbg_rdata", 32'(dbg_rdata), 32'(m_rf[dbg_sel]));
        if (m_idle) check_val("alu_idle_zero", {8'h00, alu_instr, alu_rs1, alu_rd}, 32'h0);
        acked = 1'b0;
        if (m_fetch) begin
            if (wcnt == 0) begin
                imem_ack = 1'b1;
                imem_rdata = mem[imem_addr];
                m_instr = mem[m_pc];
                acked = 1'b1;
            end else begin
                imem_ack = 1'b0;
                imem_rdata = 8'($urandom);
                wcnt--;
            end
        end else begin
            imem_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 8'($urandom);
        end
        fetch_prev = m_fetch;
        addr_prev = imem_addr;
        if (exp_ret) begin
            apply_instr(m_instr);
            ack_cnt = -1;
            if (run) begin
                m_fetch = 1'b1;
                next_wait(wcnt);
            end else begin
                m_idle = 1'b1;
            end
        end else if (m_idle) begin
            if (dbg_we) m_rf[dbg_sel] = dbg_wdata;
            if (run) begin
                m_idle = 1'b0;
                m_fetch = 1'b1;
                next_wait(wcnt);
            end
        end
        if (acked) begin
            m_fetch = 1'b0;
            ack_cnt = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        run = 1'b0; dbg_we = 1'b0; imem_ack = 1'b0; dbg_sel = 2'd0; dbg_wdata = 8'h00;
        rst_n = 1'b0;
        model_init();
        @(negedge clk);
        @(negedge clk);
        check_val("rst_imem_req", 32'(imem_req), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_retire", 32'(retire), 32'h0);
        check_val("rst_alu_zero", {8'h00, alu_instr, alu_rs1, alu_rd}, 32'h0);
        check_val("rst_imem_addr", 32'(imem_addr), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic dbg_write(input logic [1:0] sel, input logic [7:0] data);
        dbg_we = 1'b1; dbg_sel = sel; dbg_wdata = data;
        tick();
        dbg_we = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (m_idle && !busy) break;
            tick();
        end
        check_val(tag, 32'(busy), 32'h0);
    endtask

    task automatic exec_one();
        run = 1'b1;
        tick();
        run = 1'b0;
        wait_idle("exec_one_idle");
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    task automatic branch_at_4(input logic [7:0] r1v, input logic [7:0] exp_pc, input string tag);
        do_reset();
        fill_mem(8'hF4);
        mem[4] = 8'h15;
        for (int i = 0; i < 4; i++) exec_one();
        dbg_write(2'd0, 8'h07);
        dbg_write(2'd1, r1v);
        exec_one();
        exec_one();
        check_val(tag, 32'(last_fetch_addr), 32'(exp_pc));
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; retire_cnt = 0;
        rand_wait = 1'b0; rand_ack = 1'b0;
        imem_rdata = 8'h00;

        // Free-running zero-wait fetch of no-ops.
        do_reset();
        fill_mem(8'hF4);
        fetch_log.delete();
        retire_cnt = 0;
        run = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_val("seq_addr0", 32'(fetch_log[0]), 32'h0);
        check_val("seq_addr1", 32'(fetch_log[1]), 32'h1);
        check_val("seq_addr2", 32'(fetch_log[2]), 32'h2);
        check_val("retire_count", 32'(retire_cnt), 32'd3);
        run = 1'b0;
        wait_idle("seq_stop_idle");

        // ADD r1 = r2 + r1.
        do_reset();
        fill_mem(8'hF4);
        mem[0] = 8'h98;
        dbg_write(2'd1, 8'h05);
        dbg_write(2'd2, 8'h03);
        exec_one();
        dbg_sel = 2'd1;
        #1;
        check_val("add_r1", 32'(dbg_rdata), 32'h08);
        exec_one();
        check_val("add_pc", 32'(last_fetch_addr), 32'h01);

        branch_at_4(8'h07, 8'd9, "beq_taken_pc");
        branch_at_4(8'h08, 8'd5, "beq_not_taken_pc");

        // Walk to 0xF0 through taken BEQs, then BLT with PC wrap.
        do_reset();
        fill_mem(8'hF4);
        mem[0] = 8'hFD; mem[63] = 8'hFD; mem[126] = 8'hFD; mem[189] = 8'hCD; mem[240] = 8'hFF;
        for (int i = 0; i < 4; i++) exec_one();
        check_val("walk_pc", 32'(last_fetch_addr), 32'hBD);
        dbg_write(2'd0, 8'h02);
        dbg_write(2'd1, 8'h09);
        exec_one();
        check_val("blt_at_f0", 32'(last_fetch_addr), 32'hF0);
        exec_one();
        check_val("blt_wrap_pc", 32'(last_fetch_addr), 32'h2F);

        // Four wait cycles in FETCH, then run dropped during EXEC.
        do_reset();
        fill_mem(8'hF4);
        force_wait = 4;
        run = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack_cnt == 0) break;
            tick();
            n++;
        end
        check_val("fetch_wait_cycles", 32'(n), 32'd5);
        run = 1'b0;
        tick();
        tick();
        tick();
        check_val("drop_run_idle", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a fetch.
        do_reset();
        fill_mem(8'hF4);
        mem[0] = 8'h98;
        dbg_write(2'd1, 8'h05);
        dbg_write(2'd2, 8'h03);
        exec_one();
        force_wait = 8;
        run = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_req_drop", 32'(imem_req), 32'h0);
        check_val("async_busy", 32'(busy), 32'h0);
        check_val("async_pc", 32'(imem_addr), 32'h0);
        model_init();
        run = 1'b0;
        @(negedge clk);
        check_val("async_retire", 32'(retire), 32'h0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check_val("async_rf", 32'(dbg_rdata), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exec_one();
        check_val("after_reset_pc", 32'(last_fetch_addr), 32'h0);

        // Random programs, waits, stray acks, debug traffic and run toggling.
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rand_wait = 1'b1;
        rand_ack = 1'b1;
        for (int i = 0; i < 4; i++) dbg_write(2'(i), 8'($urandom));
        for (int i = 0; i < 3000; i++) begin
            run = ($urandom_range(0, 7) != 0);
            dbg_we = ($urandom_range(0, 5) == 0);
            dbg_sel = 2'($urandom_range(0, 3));
            dbg_wdata = 8'($urandom);
            tick();
        end
        run = 1'b0;
        dbg_we = 1'b0;
        wait_idle("random_final_idle");
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/glorb_sequencer.md
# glorb_sequencer

Multi-cycle control unit for the glorbcore 8-bit datapath. It fetches one instruction at a time from instruction memory over a req/ack handshake, owns the 4-entry register file and the PC, drives the combinational ALU's instruction and operand inputs, and commits the ALU result either to a register (R-type) or to the PC (B-type). It sits between the instruction memory and the ALU and is the only writer of architectural state.

## Interface
- DW, 8, data/register width
- IW, 8, instruction width; instruction formats below are defined for IW = 8 only
- AW, 8, PC / imem address width
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low
- run  in  1  level: fetch and execute while high
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address (= PC)
- imem_ack  in  1  fetch data valid
- imem_rdata  in  IW  fetched instruction
- alu_instr  out  IW  latched instruction to ALU
- alu_rs1  out  DW  ALU rs1 operand
- alu_rd  out  DW  ALU rd operand
- alu_out  in  DW  ALU result
- retire  out  1  one-cycle pulse per committed instruction
- busy  out  1  high in any state other than IDLE
- dbg_we  in  1  debug register write, honoured only in IDLE
- dbg_sel  in  2  debug register index (read and write)
- dbg_wdata  in  DW  debug write data
- dbg_rdata  out  DW  combinational read of rf[dbg_sel]

## Operation
- Instruction bit 0 selects the type: 0 = R, 1 = B.
- R-type fields: rs1 = [7:6], rd = [5:4], funct = [3:2]; bit 1 is ignored.
- B-type fields: imm = [7:2] (6-bit unsigned); funct = [1] (0 = BEQ, 1 = BLT, unsigned compare).
- Operands: R-type uses alu_rs1 = rf[rs1] and alu_rd = rf[rd]. B-type uses alu_rs1 = rf[0] and alu_rd = rf[1].
- States:
  - IDLE: move to FETCH when run = 1.
  - FETCH: imem_req = 1, imem_addr = pc. On imem_ack, latch imem_rdata into instr and move to EXEC.
  - EXEC: alu_instr = instr. Register alu_out into res and move to WB.
  - WB:
    - R-type: rf[rd] = res; pc = pc + 1.
    - B-type: pc = pc + res (mod 2^AW).
    - Pulse retire, then go to FETCH if run = 1, otherwise IDLE.
- The ALU returns 1 for a branch that is not taken, so the PC advances by 1. A taken branch with imm = 0 is a self-loop and is legal.
- Dropping run mid-instruction does not abort it. The instruction completes and the sequencer returns to IDLE.
- imem_ack is ignored outside FETCH.
- dbg_we outside IDLE is ignored.

## Timing
- Reset values: state IDLE, pc 0, rf all 0, instr 0, res 0, imem_req 0, retire 0, busy 0. alu_instr, alu_rs1 and alu_rd are 0 in IDLE.
- Reset asserted mid-FETCH drops imem_req immediately, without waiting for a clock edge.
- Minimum 3 cycles per instruction (FETCH with same-cycle ack, EXEC, WB). Each wait cycle in FETCH adds 1.
- imem_addr is stable while imem_req is high, and imem_req stays high until ack.
- Register writes become visible to the operand muxes in the cycle after WB, i.e. to the next instruction's EXEC. No bypass is needed.
- The debug write takes effect at the clock edge. If dbg_we and a rising run coincide in the same IDLE cycle, the write lands and FETCH starts in the next cycle.

## Configuration
- GLORB_SEQ_STEP_EN defined:
  - Adds input `step`.
  - In IDLE, a step pulse runs exactly one instruction regardless of run, then returns to IDLE.
  - A step that arrives while busy is dropped.
- GLORB_SEQ_STEP_EN undefined: no `step` port, and only run starts execution.

## Structure
- A shared package `glorb_pkg` holds:
  - the OP_R/OP_B, R_ADD/AND/OR/XOR and B_BEQ/B_BLT encodings;
  - the field bit positions;
  - the state enum {IDLE, FETCH, EXEC, WB}.
- Sub-module `glorb_regfile`:
  - 4×DW registers, async-reset to 0;
  - 3 combinational read ports (rs1, rd, dbg);
  - 1 write port, where the WB write has priority over dbg.
- The ALU is instantiated by the parent core, not inside this block.

## Test plan
- Reset then run = 1 with zero-wait ack: imem_addr sequence 0, 1, 2; retire every 3rd cycle.
- Debug load r1 = 0x05, r2 = 0x03; fetch 0x98 (ADD, rs1 = 2, rd = 1) -> r1 = 0x08, pc = 1.
- r0 = 0x07, r1 = 0x07; fetch 0x15 (BEQ, imm = 5) at pc 4 -> pc = 9. With r1 = 0x08 -> pc = 5.
- r0 = 0x02, r1 = 0x09; fetch 0xFF (BLT, imm = 63) at pc 0xF0 -> pc = 0x2F (wrap).
- ack held low 4 cycles: imem_req and imem_addr stay stable, no retire. Drop run during EXEC -> WB completes, then IDLE, busy = 0.
- rst_n pulsed low mid-FETCH -> imem_req = 0 asynchronously; pc, rf and retire are at reset values.
